// File: rtl/avalon_burst_ram.sv
// Purpose : parametrised single-port RAM behind an Avalon-MM slave with
//           byte-enabled writes and incrementing read/write bursts.
// Latency : write commits on its accepting edge; a read beat issued on edge t
//           returns readdatavalid/readdata READ_LATENCY cycles later.
// Backpr. : waitrequest is high only while a read burst streams out its
//           remaining beats; it is decoded from registered state, never from inputs.
//
// Ports:
//   clk, reset_n                  single clock, async active-low reset
//   address/read/write            command; address is the first beat's word address
//   writedata/byteenable          write beat payload and per-byte enables
//   burstcount                    beats in burst, sampled on the first beat (0 == 1)
//   waitrequest                   command not accepted this cycle
//   readdata/readdatavalid        returned read beat, one strobe per beat
module avalon_burst_ram #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int BC_W         = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [BC_W-1:0]       burstcount,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RBURST = 2'd1;
  localparam logic [1:0] S_WBURST = 2'd2;

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Burst tracking: addr_q is the word of the next beat, cnt_q the beats still owed.
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [BC_W-1:0]   cnt_q,   cnt_d;

  // Per-cycle memory port controls.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BE_W-1:0]   wr_be;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [BC_W-1:0]   first_rem;

  // Read-return pipeline; stage READ_LATENCY-1 drives the outputs.
  logic [READ_LATENCY-1:0] pvld_q, pvld_d;
  logic [DATA_W-1:0]       pdat_q [READ_LATENCY];
  logic [DATA_W-1:0]       pdat_d [READ_LATENCY];

  // ---------------------------------------------------------------------------
  // Command decode and burst sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_addr   = addr_q;
    wr_be     = byteenable;
    rd_en     = 1'b0;
    rd_addr   = addr_q;
    // Beats remaining after the first one; burstcount of 0 means a single beat.
    first_rem = (burstcount == '0) ? '0 : burstcount - BC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (write) begin
          // Write has priority; a simultaneous read is dropped.
          wr_en   = 1'b1;
          wr_addr = address;
          addr_d  = address + ADDR_W'(1);
          cnt_d   = first_rem;
          if (first_rem != '0) begin
            state_d = S_WBURST;
          end
        end else if (read) begin
          rd_en   = 1'b1;
          rd_addr = address;
          addr_d  = address + ADDR_W'(1);
          cnt_d   = first_rem;
          if (first_rem != '0) begin
            state_d = S_RBURST;
          end
        end
      end

      S_RBURST: begin
        // One beat per cycle; the edge issuing the last beat also returns to
        // IDLE so a new command can be taken on the very next edge.
        rd_en   = 1'b1;
        rd_addr = addr_q;
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - BC_W'(1);
        if (cnt_q == BC_W'(1)) begin
          state_d = S_IDLE;
        end
      end

      S_WBURST: begin
        // Only write matters here; gaps (write=0) simply hold the count.
        if (write) begin
          wr_en   = 1'b1;
          wr_addr = addr_q;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - BC_W'(1);
          if (cnt_q == BC_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-return pipeline. Each stage only loads when a valid beat arrives, so
  // the last stage (readdata) holds its value between strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    pvld_d[0] = rd_en;
    pdat_d[0] = rd_en ? mem[rd_addr] : pdat_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pdat_d[i] = pvld_q[i-1] ? pdat_q[i-1] : pdat_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pvld_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pdat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pvld_q  <= pvld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pdat_q[i] <= pdat_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-enabled write port. Disabled bytes keep their old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  assign waitrequest   = (state_q == S_RBURST);
  assign readdatavalid = pvld_q[READ_LATENCY-1];
  assign readdata      = pdat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_burst_ram.sv
// Purpose : directed self-checking bench for avalon_burst_ram (READ_LATENCY=3).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : read bursts are observed through waitrequest cycle counts.
module tb_avalon_burst_ram;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [3:0]  burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_burst_ram #(
    .DATA_W(32), .ADDR_W(10), .BC_W(4), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .burstcount(burstcount), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; burstcount = 4'd1; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic issue_read(input logic [9:0] a, input logic [3:0] bc);
    address = a; burstcount = bc; read = 1'b1;
    step();
    read = 1'b0;
  endtask

  // Observation index (1 = just after the accepting edge) of the first strobe; -1 on timeout.
  task automatic wait_rdv(output int lat, output logic [31:0] d);
    int i;
    lat = -1; d = 32'h0; i = 1;
    while (lat < 0 && i <= 20) begin
      if (readdatavalid === 1'b1) begin
        lat = i; d = readdata;
      end else begin
        step(); i++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read = 0; write = 0; address = 0; writedata = 0;
    byteenable = 4'hF; burstcount = 4'd1;
    #2;
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest: got %b expected 0", waitrequest); end
    checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b expected 0", readdatavalid); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", readdata); end
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic_and_async_reset();
    int lat; logic [31:0] d; int n;
    do_write(10'd5, 32'hDEADBEEF, 4'hF);
    issue_read(10'd5, 4'd1);
    wait_rdv(lat, d);
    checks++; if (lat !== L) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, L); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data: got %h expected deadbeef", d); end
    // Drop reset in the middle of a 4-beat burst while data is being returned.
    issue_read(10'd5, 4'd4);
    step(); step();
    checks++; if (readdatavalid !== 1'b1 || waitrequest !== 1'b1) begin errors++; $display("FAIL midrun_pre: got rdv=%b wr=%b expected rdv=1 wr=1", readdatavalid, waitrequest); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL async_waitrequest: got %b expected 0", waitrequest); end
    checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL async_rdv: got %b expected 0", readdatavalid); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL async_readdata: got %h expected 00000000", readdata); end
    step(); step();
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin step(); if (readdatavalid) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL async_no_rdv_after: got %0d strobes expected 0", n); end
  endtask

  task automatic test_byte_enables();
    int lat; logic [31:0] d;
    do_write(10'd3, 32'h11223344, 4'hF);
    do_write(10'd3, 32'hAABBCCDD, 4'b0101);
    issue_read(10'd3, 4'd1);
    wait_rdv(lat, d);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL byteenable_data: got %h expected 11bb33dd", d); end
  endtask

  task automatic test_read_burst_wrap();
    int wq, nrv, first, last; logic [31:0] got [4];
    do_write(10'd1022, 32'hA0, 4'hF);
    do_write(10'd1023, 32'hA1, 4'hF);
    do_write(10'd0,    32'hA2, 4'hF);
    do_write(10'd1,    32'hA3, 4'hF);
    issue_read(10'd1022, 4'd4);
    wq = 0; nrv = 0; first = -1; last = -1;
    for (int k = 0; k < 4; k++) got[k] = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      if (waitrequest) wq++;
      if (readdatavalid) begin
        if (first < 0) first = i;
        last = i;
        if (nrv < 4) got[nrv] = readdata;
        nrv++;
      end
      step();
    end
    checks++; if (wq !== 3) begin errors++; $display("FAIL rburst_waitrequest_cycles: got %0d expected 3", wq); end
    checks++; if (nrv !== 4) begin errors++; $display("FAIL rburst_beats: got %0d expected 4", nrv); end
    checks++; if (first !== L || last !== L + 3) begin errors++; $display("FAIL rburst_contiguous: got first=%0d last=%0d expected first=%0d last=%0d", first, last, L, L + 3); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== 32'(32'hA0 + k)) begin errors++; $display("FAIL rburst_data%0d: got %h expected %h", k, got[k], 32'(32'hA0 + k)); end
    end
  endtask

  task automatic test_write_burst_gaps();
    int lat; logic [31:0] d; int n;
    n = 0;
    address = 10'd8; burstcount = 4'd3; writedata = 32'hB0; byteenable = 4'hF; write = 1'b1;
    step(); if (readdatavalid) n++;
    address = 10'd100; burstcount = 4'd7; writedata = 32'hB1;
    step(); if (readdatavalid) n++;
    write = 1'b0; read = 1'b1; address = 10'd200; writedata = 32'hFFFFFFFF;
    step(); if (readdatavalid) n++;
    step(); if (readdatavalid) n++;
    read = 1'b0; write = 1'b1; writedata = 32'hB2;
    step(); if (readdatavalid) n++;
    write = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); if (readdatavalid) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL wburst_no_rdv: got %0d strobes expected 0", n); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL wburst_idle_wr: got %b expected 0", waitrequest); end
    issue_read(10'd10, 4'd1); wait_rdv(lat, d);
    checks++; if (lat !== L || d !== 32'hB2) begin errors++; $display("FAIL wburst_word10: got lat=%0d data=%h expected lat=%0d data=000000b2", lat, d, L); end
    issue_read(10'd8, 4'd1); wait_rdv(lat, d);
    checks++; if (d !== 32'hB0) begin errors++; $display("FAIL wburst_word8: got %h expected 000000b0", d); end
    issue_read(10'd9, 4'd1); wait_rdv(lat, d);
    checks++; if (d !== 32'hB1) begin errors++; $display("FAIL wburst_word9: got %h expected 000000b1", d); end
  endtask

  task automatic test_corner_commands();
    int lat; logic [31:0] d; int n, wq;
    // Simultaneous read+write: write wins, no read response.
    address = 10'd20; writedata = 32'hC0; byteenable = 4'hF; burstcount = 4'd1;
    write = 1'b1; read = 1'b1;
    step();
    write = 1'b0; read = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin if (readdatavalid) n++; step(); end
    checks++; if (n !== 0) begin errors++; $display("FAIL rdwr_no_rdv: got %0d strobes expected 0", n); end
    issue_read(10'd20, 4'd1); wait_rdv(lat, d);
    checks++; if (d !== 32'hC0) begin errors++; $display("FAIL rdwr_write_done: got %h expected 000000c0", d); end
    // burstcount=0 read behaves as one beat.
    do_write(10'd21, 32'hC1, 4'hF);
    do_write(10'd22, 32'hC2, 4'hF);
    issue_read(10'd21, 4'd0);
    n = 0; wq = 0; d = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (waitrequest) wq++;
      if (readdatavalid) begin n++; d = readdata; end
      step();
    end
    checks++; if (wq !== 0 || n !== 1 || d !== 32'hC1) begin errors++; $display("FAIL bc0_read: got wr=%0d beats=%0d data=%h expected wr=0 beats=1 data=000000c1", wq, n, d); end
    // burstcount=0 write behaves as one beat: the next single write lands where addressed.
    address = 10'd23; writedata = 32'hC3; burstcount = 4'd0; write = 1'b1;
    step();
    write = 1'b0;
    do_write(10'd30, 32'hC4, 4'hF);
    issue_read(10'd30, 4'd1); wait_rdv(lat, d);
    checks++; if (d !== 32'hC4) begin errors++; $display("FAIL bc0_write_next: got %h expected 000000c4", d); end
    issue_read(10'd23, 4'd1); wait_rdv(lat, d);
    checks++; if (d !== 32'hC3) begin errors++; $display("FAIL bc0_write: got %h expected 000000c3", d); end
    // Read on the cycle right after a write to the same word sees new data.
    do_write(10'd40, 32'h0BAD0BAD, 4'hF);
    do_write(10'd40, 32'h12345678, 4'hF);
    issue_read(10'd40, 4'd1); wait_rdv(lat, d);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL raw_same_word: got %h expected 12345678", d); end
  endtask

  task automatic test_reset_mid_burst();
    int lat; logic [31:0] d; int n;
    for (int k = 0; k < 8; k++) do_write(10'(50 + k), 32'(32'h50 + k), 4'hF);
    issue_read(10'd50, 4'd8);
    step();
    // Third beat is on the bus now; beats 0 and 1 are still in the return pipe.
    #2 reset_n = 1'b0;
    n = 0;
    #1 if (readdatavalid) n++;
    step(); if (readdatavalid) n++;
    step(); if (readdatavalid) n++;
    reset_n = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL midburst_wr_after: got %b expected 0", waitrequest); end
    for (int i = 0; i < 8; i++) begin step(); if (readdatavalid) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL midburst_no_rdv: got %0d strobes expected 0", n); end
    issue_read(10'd51, 4'd1); wait_rdv(lat, d);
    checks++; if (lat !== L || d !== 32'h51) begin errors++; $display("FAIL midburst_new_read: got lat=%0d data=%h expected lat=%0d data=00000051", lat, d, L); end
  endtask

  initial begin
    test_reset();
    test_basic_and_async_reset();
    test_byte_enables();
    test_read_burst_wrap();
    test_write_burst_gaps();
    test_corner_commands();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
